chart_note_sequencer: RTL
=========================

Name: chart_note_sequencer

Overview:
- Consumer of the frame-time count (un_time) from the song timer.
- Walks a note-chart ROM in order and emits one spawn event per note once un_time + LEAD reaches the note's hit frame, so each note can scroll in ahead of its hit.
- Stops at an end-marker entry, at the last ROM address, or when the timer asserts stop_sign. Feeds the note-object/lane logic through a valid/ready handshake.

Parameters:
- TIME_W, 16, width of un_time and of the note timestamps
- ADDR_W, 10, chart ROM address width
- LANE_W, 2, lane index width
- LEAD, 16, frames between spawn and hit

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; arms the sequencer (honoured in IDLE and DONE only)
- un_time  in  TIME_W  current song frame from the timer
- stop_sign  in  1  timer finished; ends sequencing
- rom_addr  out  ADDR_W  chart ROM address
- rom_data  in  TIME_W+LANE_W  {note_time, lane}; valid one clk after rom_addr changes
- spawn_valid  out  1  spawn event pending
- spawn_ready  in  1  consumer accepts event
- spawn_lane  out  LANE_W  lane of the pending note
- spawn_time  out  TIME_W  hit frame of the pending note
- spawn_late  out  1  un_time > spawn_time when the event was captured
- busy  out  1  high in FETCH, CHECK and SPAWN
- done  out  1  high in DONE
- note_count  out  ADDR_W+1  number of spawn events accepted since the last start

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States: IDLE, FETCH, CHECK, SPAWN, DONE.
- IDLE: on start -> FETCH with rom_addr=0 and note_count=0.
- FETCH: holds rom_addr for one cycle, then -> CHECK. If stop_sign is high -> DONE instead.
- CHECK: rom_data is valid here, and rom_addr is held so it stays valid. Evaluate in this priority order:
  1. stop_sign high -> DONE.
  2. note_time is all ones (end marker) -> DONE.
  3. Due, i.e. (un_time + LEAD) >= note_time, computed at TIME_W+1 bits with no wrap -> capture lane and time into the spawn_* registers, set spawn_late = (un_time > note_time), go to SPAWN.
  4. Otherwise stay in CHECK and re-evaluate every cycle.
- SPAWN:
  - spawn_valid is high; spawn_lane, spawn_time and spawn_late are held stable until the handshake completes.
  - Handshake completes on any cycle with spawn_valid && spawn_ready. On that cycle: note_count+1 and spawn_valid drops. Then, if rom_addr == 2^ADDR_W-1 -> DONE (no address wrap); else rom_addr+1 -> FETCH.
  - stop_sign in SPAWN does not drop the pending event. The event completes, then -> DONE.
- Same-frame notes: each one is emitted in turn. The minimum spacing is 3 cycles per note (SPAWN, FETCH, CHECK) when spawn_ready is held high.
- Notes whose time is already past (late) are still emitted, with spawn_late=1. Entries are assumed to be in non-decreasing time order; the sequencer does not reorder.
- DONE: done=1 and busy=0; rom_addr and note_count hold. start -> FETCH with rom_addr=0 and note_count=0.
- start while busy is ignored.
- Asynchronous reset at any point returns to IDLE immediately. A pending spawn_valid is dropped with no handshake.
- un_time may jump back to 0 while in CHECK. No special action: the note waits until it becomes due again.

Test Plan:
- Chart {100,L1},{200,L3},{FFFF}; LEAD=16; un_time counts up 1 per 8 clk; spawn_ready=1 -> spawn at un_time=84 (lane1, time100, late0) and at 184 (lane3, time200); then done=1, note_count=2.
- Three entries at time 50, lanes 0/1/2; un_time fixed at 40; ready=1 -> three events exactly 3 clk apart, in ROM order; note_count=3.
- Entry time 10, un_time=30 at start -> spawn_late=1, spawn_time=10. Hold spawn_ready=0 for 5 clk -> valid, lane and time stay stable; accepted on the first ready cycle.
- stop_sign pulsed while in CHECK waiting on a time-500 note -> DONE next cycle, no spawn. stop_sign while in SPAWN with ready=0 -> event stays pending; after ready -> DONE.
- ADDR_W=2, ROM full of time-0 notes with no marker -> 4 spawns, then DONE with rom_addr=3 (no wrap). start again -> rom_addr=0, note_count=0, re-sequences.
- Reset asserted mid-SPAWN (asynchronously, between clock edges) -> spawn_valid, busy and done = 0 immediately; state IDLE; start and un_time ignored until the next start pulse.

Source files
------------

// File: rtl/chart_note_sequencer.sv
// ============================================================================
// Module   : chart_note_sequencer
// Purpose  : Walks a note-chart ROM and emits one spawn event per note once the
//            song time plus the scroll lead reaches the note's hit frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module chart_note_sequencer #(
    parameter int TIME_W = 16,
    parameter int ADDR_W = 10,
    parameter int LANE_W = 2,
    parameter int LEAD   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [TIME_W-1:0]         un_time,
    input  logic                      stop_sign,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [TIME_W+LANE_W-1:0]  rom_data,
    output logic                      spawn_valid,
    input  logic                      spawn_ready,
    output logic [LANE_W-1:0]         spawn_lane,
    output logic [TIME_W-1:0]         spawn_time,
    output logic                      spawn_late,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W:0]           note_count
);

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;
    localparam logic [TIME_W-1:0] c_END_MARK = '1;
    localparam logic [TIME_W:0]   c_LEAD     = (TIME_W+1)'(LEAD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_SPAWN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_spawn_valid;
    logic [LANE_W-1:0]   r_spawn_lane;
    logic [TIME_W-1:0]   r_spawn_time;
    logic                r_spawn_late;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W:0]     r_note_count;
    logic                r_stop_pend;

    logic [TIME_W-1:0]   w_note_time;
    logic [LANE_W-1:0]   w_note_lane;
    logic [TIME_W:0]     w_due_sum;
    logic                w_due;
    logic                w_end_mark;
    logic                w_late;

    assign w_note_time = rom_data[TIME_W+LANE_W-1:LANE_W];
    assign w_note_lane = rom_data[LANE_W-1:0];
    // One extra bit so that un_time near the top of its range cannot wrap past the note.
    assign w_due_sum   = {1'b0, un_time} + c_LEAD;
    assign w_due       = (w_due_sum >= {1'b0, w_note_time});
    assign w_end_mark  = (w_note_time == c_END_MARK);
    assign w_late      = (un_time > w_note_time);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rom_addr    <= '0;
            r_spawn_valid <= 1'b0;
            r_spawn_lane  <= '0;
            r_spawn_time  <= '0;
            r_spawn_late  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_note_count  <= '0;
            r_stop_pend   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_FETCH;
                        r_rom_addr   <= '0;
                        r_note_count <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_stop_pend  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (stop_sign) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (stop_sign || w_end_mark) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_due) begin
                        r_state       <= S_SPAWN;
                        r_spawn_valid <= 1'b1;
                        r_spawn_lane  <= w_note_lane;
                        r_spawn_time  <= w_note_time;
                        r_spawn_late  <= w_late;
                    end
                end
                S_SPAWN: begin
                    // A stop seen while the event is pending is remembered and acted on after the handshake.
                    if (spawn_ready) begin
                        r_spawn_valid <= 1'b0;
                        r_note_count  <= r_note_count + (ADDR_W+1)'(1);
                        r_stop_pend   <= 1'b0;
                        if (r_stop_pend || stop_sign || (r_rom_addr == c_ADDR_MAX)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        end
                    end else if (stop_sign) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_spawn_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr    = r_rom_addr;
    assign spawn_valid = r_spawn_valid;
    assign spawn_lane  = r_spawn_lane;
    assign spawn_time  = r_spawn_time;
    assign spawn_late  = r_spawn_late;
    assign busy        = r_busy;
    assign done        = r_done;
    assign note_count  = r_note_count;

endmodule

`default_nettype wire
